// File: rtl/latch_load_sequencer_if.sv
// rtl/latch_load_sequencer_if.sv - handshake and latch-side signal bundle for latch_load_sequencer
interface latch_load_sequencer_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] lat_d;
    logic             lat_en;
    logic             busy;
    logic             done;
`ifdef LATCH_SEQ_READBACK_EN
    logic [WIDTH-1:0] lat_q;
    logic             rb_err;

    modport master (output in_valid, in_data, lat_q,
                    input  in_ready, lat_d, lat_en, busy, done, rb_err);
    modport slave  (input  in_valid, in_data, lat_q,
                    output in_ready, lat_d, lat_en, busy, done, rb_err);
`else
    modport master (output in_valid, in_data,
                    input  in_ready, lat_d, lat_en, busy, done);
    modport slave  (input  in_valid, in_data,
                    output in_ready, lat_d, lat_en, busy, done);
`endif
endinterface

// File: rtl/latch_load_sequencer.sv
// rtl/latch_load_sequencer.sv - guarded D/enable sequencer for a transparent latch; readback under LATCH_SEQ_READBACK_EN
module latch_load_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    latch_load_sequencer_if.slave bus
);
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_OPEN  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last;

    assign last         = (cnt == CW'(1));
    assign bus.in_ready = (state == S_IDLE) && !rst;
    assign bus.busy     = (state != S_IDLE);

    // lat_en is set/cleared on the same edges that enter/leave OPEN, so it is a pure flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bus.lat_d  <= '0;
            bus.lat_en <= 1'b0;
            bus.done   <= 1'b0;
`ifdef LATCH_SEQ_READBACK_EN
            bus.rb_err <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.lat_d <= bus.in_data;
                        cnt       <= CW'(SETUP_CYC);
                        state     <= S_SETUP;
`ifdef LATCH_SEQ_READBACK_EN
                        bus.rb_err <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    if (last) begin
                        cnt        <= CW'(PULSE_CYC);
                        state      <= S_OPEN;
                        bus.lat_en <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_OPEN: begin
                    if (last) begin
                        cnt        <= CW'(HOLD_CYC);
                        state      <= S_HOLD;
                        bus.lat_en <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (last) begin
                        state    <= S_IDLE;
                        bus.done <= 1'b1;
`ifdef LATCH_SEQ_READBACK_EN
                        bus.rb_err <= (bus.lat_q != bus.lat_d);
`endif
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus.lat_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/latch_load_sequencer.md
# latch_load_sequencer

Upstream driver for the team's level-sensitive transparent latch. Accepts a data word on a valid/ready handshake and drives the latch's D and enable inputs with a guarded sequence: data stable before enable opens, enable pulse of fixed width, data held after enable closes. The latch enable therefore never glitches or opens while D is moving. Optional readback compares the latch output against the written word.

## Interface
Parameters:
- WIDTH, 8, data word width (≥1)
- SETUP_CYC, 1, cycles lat_d is stable with lat_en low before opening (≥1)
- PULSE_CYC, 2, cycles lat_en is high (≥1)
- HOLD_CYC, 1, cycles lat_d is held with lat_en low after closing (≥1)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept; high only in IDLE and not in reset
- in_data  in  WIDTH  word to load
- lat_d  out  WIDTH  to latch D; registered
- lat_en  out  1  to latch enable; registered, glitch-free
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a sequence completes
- lat_q  in  WIDTH  latch Q readback (LATCH_SEQ_READBACK_EN only)
- rb_err  out  1  readback mismatch flag (LATCH_SEQ_READBACK_EN only)

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD. One down-counter, width clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1).
- IDLE: in_ready=1. On in_valid&&in_ready, register in_data into lat_d, load counter with SETUP_CYC, go to SETUP.
- SETUP: lat_en=0 for SETUP_CYC cycles. Then load PULSE_CYC and go to OPEN.
- OPEN: lat_en=1 for PULSE_CYC cycles. Then load HOLD_CYC and go to HOLD.
- HOLD: lat_en=0 for HOLD_CYC cycles. Then go to IDLE and assert done for that first IDLE cycle.
- lat_d changes only on an accept. It holds its value through IDLE and is never cleared between transactions.
- in_data and in_valid are ignored outside IDLE. No buffering and no back-pressure queue.
- lat_en is a flop output only, never decoded combinationally.

## Timing
- Reset values: lat_d=0, lat_en=0, busy=0, done=0, rb_err=0, state=IDLE. in_ready=0 while rst is high.
- Accept in cycle T:
  - lat_d is valid from T+1.
  - lat_en is high from T+1+SETUP_CYC through T+SETUP_CYC+PULSE_CYC.
  - done is high at T+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- Back-to-back: a new accept is allowed in the done cycle. Throughput is one word per 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- in_ready is combinational from state and rst. It never depends on in_valid.
- Reset mid-sequence: lat_en and lat_d go to 0 immediately (asynchronous). The transaction is abandoned with no done pulse. in_ready=1 in the first cycle after rst deasserts.

## Configuration
- LATCH_SEQ_READBACK_EN defined:
  - lat_q and rb_err ports exist.
  - In the last HOLD cycle, lat_q is compared to lat_d. rb_err is registered as the result, so it is valid in the done cycle.
  - rb_err holds until the next accept, which clears it. Reset clears it.
- LATCH_SEQ_READBACK_EN undefined: lat_q and rb_err ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-run → lat_en=0 and lat_d=0 in the same cycle, no done. After release, in_ready=1 next cycle.
- Single load, defaults, in_data=8'hA5 accepted at T:
  - lat_d=A5 at T+1.
  - lat_en high exactly in T+2 and T+3.
  - done at T+5.
  - in_ready low from T+1 through T+4.
- Back-to-back: 8'h3C accepted at T, 8'hC3 offered continuously → second accept in the done cycle T+5. lat_d is never changed while lat_en=1.
- Ignored input: toggle in_valid/in_data during SETUP/OPEN/HOLD → lat_d unchanged, no extra sequence started.
- Non-default timing (SETUP=3, PULSE=1, HOLD=2) → lat_en high 1 cycle starting T+4, done at T+7.
- Readback (macro on):
  - Model latch with lat_q following lat_d while lat_en is high → rb_err=0 at done.
  - Force lat_q=8'h00 for data 8'hFF → rb_err=1 at done, cleared on the next accept.
